addpg_serial: RTL and testbench
===============================

Name: addpg_serial

Overview:
Parametrised digit-serial adder built from the 1-bit propagate/generate adder cell.
- Adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
- Keeps a registered carry between digits.
- Reports sum, carry-out, signed overflow and group propagate/generate.
- Serves as an area-reduced adder for multi-cycle datapath units (multiply/divide helpers) in the core.

Parameters:
WIDTH  32  operand/sum width in bits; must be a multiple of DIGIT.
DIGIT  4   bits processed per clock; 1 <= DIGIT <= WIDTH.

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      synchronous active-low reset
start  input   1      request new operation; accepted only when ready=1
a      input   WIDTH  operand A, sampled on the accepting edge
b      input   WIDTH  operand B, sampled on the accepting edge
cin    input   1      carry-in, sampled on the accepting edge
ready  output  1      block can accept start this cycle
busy   output  1      operation in progress
done   output  1      one-cycle pulse: results valid
s      output  WIDTH  sum
cout   output  1      carry out of bit WIDTH-1
ovf    output  1      signed overflow: carry into MSB XOR cout
p_grp  output  1      group propagate: AND over all bits of (a[i]^b[i])
g_grp  output  1      group generate: carry-out that would occur with cin=0

Behaviour:
- Reset is synchronous and active-low on clk. It applies one clock; the rising edge with rst_n=0 forces:
  - state=IDLE; ready=1; busy=0; done=0
  - s=0, cout=0, ovf=0, p_grp=0, g_grp=0
  - internal carry, digit counter and operand registers cleared
- Reset overrides start.
- N = WIDTH/DIGIT digit cycles.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1, busy=0.
  - start=1 at an edge: latch a, b, cin into the operand registers; counter=0; p/g accumulators set to p=1, g=0; go to RUN.
- RUN:
  - ready=0, busy=1.
  - Each edge processes digit k = counter, bits [k*DIGIT +: DIGIT], using the per-bit rules:
    - p_i = a_i ^ b_i
    - g_i = a_i & b_i
    - s_i = p_i ^ c_i
    - c_{i+1} = g_i | (p_i & c_i)
  - The digit carry-out is registered as the next digit's carry-in.
  - The digit's sum bits are written into s.
  - Group accumulators update each digit:
    - p_acc &= all p_i of the digit
    - g_acc = G_digit | (P_digit & g_acc)
  - At the edge processing digit N-1: commit cout, ovf, p_grp, g_grp; go to DONE.
- DONE:
  - done=1 for exactly this one cycle; ready=1; busy=0.
  - Next edge: start=1 goes to RUN with new operands (back-to-back); otherwise goes to IDLE.
- Latency: start accepted at edge t0 -> done=1 during the cycle after edge t0+N. Throughput is one result per N+1 cycles with back-to-back starts.
- Outputs s, cout, ovf, p_grp and g_grp:
  - hold their values from DONE until the next accepted start;
  - may change digit-by-digit during RUN and are not valid until done.
- start while busy=1: ignored; the operation in flight is unaffected.
- a, b, cin changing during RUN: no effect (latched copies are used).
- Reset mid-RUN: abort; done is not pulsed; all outputs take their reset values.
- DIGIT=WIDTH: N=1, so done follows the accepting edge by one cycle.
- Arithmetic is modulo 2^WIDTH; cout carries the overflow bit. ovf is computed from the carry into bit WIDTH-1 and cout.

Optional Feature:
Macro ADDPG_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1, the latched B is ~b and the latched carry-in is 1 (cin ignored), so s = a - b.
  - cout=1 means no borrow; ovf, p_grp and g_grp are computed on the inverted operand.
  - When sub=0, behaviour is identical to the base block.
- Not defined: no sub port; the block always adds.

Test Plan:
All cases use WIDTH=8, DIGIT=2 (N=4).
1. rst_n=0 for 2 cycles with start=1 -> ready=1, busy=0, done=0, s=8'h00, cout=0, ovf=0, p_grp=0, g_grp=0; no operation starts.
2. a=8'h3C, b=8'h0F, cin=0, start pulse -> busy for 4 cycles; done in the 5th cycle after the accepting edge; s=8'h4B, cout=0, ovf=0, p_grp=0, g_grp=0.
3. a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1, ovf=0, g_grp=1, p_grp=0. Then a=8'h7F, b=8'h01, cin=0 -> s=8'h80, cout=0, ovf=1.
4. a=8'h55, b=8'hAA, cin=1 -> s=8'h00, cout=1, p_grp=1, g_grp=0, ovf=0. Then with start held high through DONE, a=8'h01, b=8'h01 -> back-to-back accept, next done gives s=8'h02.
5. Accept a=8'h10, b=8'h20. During RUN: pulse start with a=8'hFF, and pull rst_n low on the 2nd RUN cycle -> the second start is ignored; after the reset edge busy=0, s=0, and no done pulse occurs.
6. With ADDPG_SUB_EN: a=8'h05, b=8'h07, sub=1 -> s=8'hFE, cout=0. Then a=8'h07, b=8'h05, sub=1 -> s=8'h02, cout=1.

Source files
------------

// File: rtl/addpg_serial.sv
// addpg_serial -- digit-serial propagate/generate adder.
//
// Adds two WIDTH-bit operands DIGIT bits per clock, least significant digit
// first. The carry between digits is registered. A full add takes
// N = WIDTH/DIGIT RUN cycles, followed by a one-cycle DONE pulse.
//
// Parameters:
//   WIDTH  operand/sum width, must be a multiple of DIGIT
//   DIGIT  bits processed per clock, 1..WIDTH
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request a new operation (taken when ready=1)
//   a, b   operands, latched on the accepting edge
//   cin    carry-in, latched on the accepting edge
//   sub    (ADDPG_SUB_EN only) subtract: latch ~b with carry-in forced to 1
//   ready  block can accept start this cycle (IDLE or DONE)
//   busy   operation in progress (RUN)
//   done   one-cycle pulse, results valid
//   s      sum
//   cout   carry out of bit WIDTH-1
//   ovf    signed overflow (carry into MSB xor cout)
//   p_grp  group propagate over all bits
//   g_grp  group generate (carry-out with cin=0)
//
// Optional feature: define ADDPG_SUB_EN to add the sub port.

module addpg_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDPG_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             p_grp,
    output logic             g_grp
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, nstate;

    logic [WIDTH-1:0] opa, opb;     // operands, shifted right one digit per RUN cycle
    logic             carry;        // carry into the current digit
    logic [CW-1:0]    cnt;          // current digit index
    logic             p_acc, g_acc; // group propagate/generate over digits done so far

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] lat_b;
    logic             lat_c;

    // Digit cell outputs
    logic [DIGIT-1:0] dsum;
    logic             dc;           // ripple carry through the digit
    logic             cmsb;         // carry into the top bit of the digit
    logic             pd, gd;       // digit propagate / generate

    assign accept = start && (state != S_RUN);
    assign last   = (state == S_RUN) && (cnt == CW'(N - 1));

`ifdef ADDPG_SUB_EN
    assign lat_b = sub ? ~b : b;
    assign lat_c = sub ? 1'b1 : cin;
`else
    assign lat_b = b;
    assign lat_c = cin;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (start) nstate = S_RUN;
            S_RUN:   if (last)  nstate = S_DONE;
            S_DONE:  nstate = start ? S_RUN : S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE:  ready = 1'b1;
            S_RUN:   busy  = 1'b1;
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b1;
        endcase
    end

    // Propagate/generate cells for the low digit of the operand registers.
    // gd is the carry the digit would produce with carry-in 0.
    always_comb begin
        dsum = '0;
        dc   = carry;
        cmsb = carry;
        pd   = 1'b1;
        gd   = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) cmsb = dc;
            dsum[i] = (opa[i] ^ opb[i]) ^ dc;
            dc      = (opa[i] & opb[i]) | ((opa[i] ^ opb[i]) & dc);
            pd      = pd & (opa[i] ^ opb[i]);
            gd      = (opa[i] & opb[i]) | ((opa[i] ^ opb[i]) & gd);
        end
    end

    // Datapath: latch on accept, one digit per RUN cycle, commit flags on last digit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            p_acc <= 1'b0;
            g_acc <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            p_grp <= 1'b0;
            g_grp <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= lat_b;
            carry <= lat_c;
            cnt   <= '0;
            p_acc <= 1'b1;
            g_acc <= 1'b0;
        end else if (state == S_RUN) begin
            s[int'(cnt) * DIGIT +: DIGIT] <= dsum;
            carry <= dc;
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            cnt   <= cnt + 1'b1;
            p_acc <= p_acc & pd;
            g_acc <= gd | (pd & g_acc);
            if (last) begin
                cout  <= dc;
                ovf   <= cmsb ^ dc;
                p_grp <= p_acc & pd;
                g_grp <= gd | (pd & g_acc);
            end
        end
    end

endmodule

// File: tb/tb_addpg_serial.sv
// Testbench for addpg_serial with WIDTH=8, DIGIT=2 (4 digit cycles).
// Directed cases followed by random operations, checked against an
// arithmetic reference model.

module tb_addpg_serial;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

`ifdef ADDPG_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic         ready, busy, done;
    logic [W-1:0] s;
    logic         cout, ovf, p_grp, g_grp;

    int n_assert = 0;
    int n_fail   = 0;
    logic [11:0] last_e = '0;   // {cout, ovf, p_grp, g_grp, s} of last result

    always #5 clk = ~clk;

    addpg_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef ADDPG_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .p_grp (p_grp),
        .g_grp (g_grp)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    // Reference: plain integer addition on the effective operands.
    function automatic logic [11:0] model(input logic [7:0] ta, input logic [7:0] tb_,
                                          input logic tc, input logic ts);
        logic [7:0] bb;
        logic       cc;
        logic [8:0] full, nocin;
        logic [7:0] low;
        bb    = ts ? ~tb_ : tb_;
        cc    = ts ? 1'b1 : tc;
        full  = {1'b0, ta} + {1'b0, bb} + {8'd0, cc};
        nocin = {1'b0, ta} + {1'b0, bb};
        low   = {1'b0, ta[6:0]} + {1'b0, bb[6:0]} + {7'd0, cc};
        return {full[8], low[7] ^ full[8], ((ta ^ bb) == 8'hFF), nocin[8], full[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation. b2b: caller is in the DONE cycle and starts immediately.
    // keep_start: start stays high into DONE so the next op is back-to-back.
    task automatic op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                      input logic ts, input bit b2b, input bit keep_start);
        logic [11:0] e;
        e = model(ta, tbv, tc, ts);
        if (!b2b) begin
            @(negedge clk);
            chk("idle_hold", {done, ready, busy, cout, ovf, p_grp, g_grp, s},
                {3'b010, last_e});
        end
        a = ta; b = tbv; cin = tc; sub = ts; start = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("run_flags", {done, ready, busy}, 3'b001);
            if (k == N - 1) begin
                start = keep_start;
            end else begin
                start = 1'($urandom);
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        @(negedge clk);
        chk("done_flags", {done, ready, busy}, 3'b110);
        chk("result", {cout, ovf, p_grp, g_grp, s}, e);
        last_e = e;
    endtask

    initial begin
        bit k, nk;
        logic ts;

        // 1: reset held two cycles with start asserted
        rst_n = 1'b0; start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_state", {ready, busy, done, s, cout, ovf, p_grp, g_grp},
                {3'b100, 8'h00, 4'b0000});
        end
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {ready, busy, done}, 3'b100);

        // 2: basic add
        op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_const", {s, cout, ovf, p_grp, g_grp}, {8'h4B, 4'b0000});

        // 3: carry out, then signed overflow
        op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3a_const", {s, cout, ovf, p_grp, g_grp}, {8'h00, 4'b1001});
        op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3b_const", {s, cout, ovf}, {8'h80, 2'b01});

        // 4: full propagate, then back-to-back start from DONE
        op(8'h55, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4a_const", {s, cout, ovf, p_grp, g_grp}, {8'h00, 4'b1010});
        op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4b_const", s, 8'h02);

        // 5: start during RUN ignored, reset mid-RUN aborts
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("t5_run1", {ready, busy}, 2'b01);
        start = 1'b1; a = 8'hFF;
        @(negedge clk);
        chk("t5_run2", {ready, busy}, 2'b01);
        start = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("t5_reset", {ready, busy, done, s, cout, ovf, p_grp, g_grp},
            {3'b100, 8'h00, 4'b0000});
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_done", {done, busy}, 2'b00);
        end
        last_e = '0;

        // 6: subtraction
        if (HAS_SUB) begin
            op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("t6a_const", {s, cout}, {8'hFE, 1'b0});
            op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("t6b_const", {s, cout}, {8'h02, 1'b1});
        end

        // Random operations, some back-to-back
        k = 1'b0;
        for (int i = 0; i < 30; i++) begin
            nk = (i == 29) ? 1'b0 : 1'($urandom);
            ts = HAS_SUB ? 1'($urandom) : 1'b0;
            op(8'($urandom), 8'($urandom), 1'($urandom), ts, k, nk);
            k = nk;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
